// File: rtl/fft_piso.sv
// fft_piso: ping-pong parallel-in/serial-out drainer for 16-bin FFT frames.
// Define FFT_PISO_HALF_EN to store and emit only bins 0..8 of each frame.
module fft_piso #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fft_valid,
  input  logic [DW-1:0] fft_d0,
  input  logic [DW-1:0] fft_d1,
  input  logic [DW-1:0] fft_d2,
  input  logic [DW-1:0] fft_d3,
  input  logic [DW-1:0] fft_d4,
  input  logic [DW-1:0] fft_d5,
  input  logic [DW-1:0] fft_d6,
  input  logic [DW-1:0] fft_d7,
  input  logic [DW-1:0] fft_d8,
  input  logic [DW-1:0] fft_d9,
  input  logic [DW-1:0] fft_d10,
  input  logic [DW-1:0] fft_d11,
  input  logic [DW-1:0] fft_d12,
  input  logic [DW-1:0] fft_d13,
  input  logic [DW-1:0] fft_d14,
  input  logic [DW-1:0] fft_d15,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_d,
  output logic [3:0]    out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
);
`ifdef FFT_PISO_HALF_EN
  localparam int NW = 9;
  logic [DW-1:0] din [NW];
  logic          unused_hi;
  assign din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7, fft_d8};
  assign unused_hi = ^{fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
`else
  localparam int NW = 16;
  logic [DW-1:0] din [NW];
  assign din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                 fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
`endif
  localparam logic [3:0] LAST = 4'(NW - 1);
  logic [DW-1:0] bank [2][NW];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [3:0]    idx;
  logic          accept;
  logic          fin;
  logic          cap;
  logic          drop;
  // A full buffer still takes a frame when the head frame retires this cycle.
  always_comb begin
    accept    = out_valid && out_ready;
    fin       = accept && idx == LAST;
    cap       = fft_valid && (count != 2'd2 || fin);
    drop      = fft_valid && !cap;
    count_nxt = count + 2'(cap) - 2'(fin);
  end
  assign out_valid = count != 2'd0;
  assign busy      = out_valid;
  assign out_d     = bank[rd_ptr][idx];
  assign out_idx   = idx;
  assign out_last  = out_valid && idx == LAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < NW; k++)
          bank[b][k] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      idx      <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (cap) begin
        for (int k = 0; k < NW; k++)
          bank[wr_ptr][k] <= din[k];
        wr_ptr <= !wr_ptr;
      end
      if (accept) idx <= fin ? 4'd0 : idx + 4'd1;
      if (fin) rd_ptr <= !rd_ptr;
      count    <= count_nxt;
      overflow <= overflow | drop;
    end
  end
endmodule

// File: tb/tb_fft_piso.sv
// tb_fft_piso: directed self-checking bench for fft_piso (honours FFT_PISO_HALF_EN).
module tb_fft_piso;
`ifdef FFT_PISO_HALF_EN
  localparam int NB = 9;
`else
  localparam int NB = 16;
`endif
  typedef struct {
    logic       rdy;
    logic       ev;
    int         eidx;
    logic       el;
    logic [31:0] ed;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fft_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] fd [16];
  logic        out_valid;
  logic [31:0] out_d;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        overflow;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  fft_piso dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
    .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
    .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .out_ready(out_ready), .out_valid(out_valid), .out_d(out_d), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .overflow(overflow)
  );
  function automatic logic [31:0] w(input int k, input logic [31:0] off);
    return 32'(32'h0001_0000 * k + k) + off;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic beat(input string tag, input int k, input logic [31:0] off);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"}, 32'(out_idx), 32'(k));
    chk({tag, "_d"}, out_d, w(k, off));
    chk({tag, "_last"}, 32'(out_last), 32'(k == NB - 1));
  endtask
  task automatic idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
  endtask
  task automatic cyc(input logic fv, input logic [31:0] off, input logic rdy);
    fft_valid = fv;
    out_ready = rdy;
    for (int k = 0; k < 16; k++) fd[k] = w(k, off);
    @(posedge clk);
    @(negedge clk);
    fft_valid = 1'b0;
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_d"}, out_d, 32'd0);
    chk({tag, "_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    zero_chk(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    vec_t        tv [$];
    logic [31:0] prev;
    for (int j = 0; j <= 2 * NB - 2; j++)
      tv.push_back('{rdy: (j % 2 == 0), ev: 1'b1, eidx: (j + 1) / 2,
                     el: ((j + 1) / 2 == NB - 1), ed: w((j + 1) / 2, 0)});
    for (int k = 0; k < 16; k++) fd[k] = '0;
    @(negedge clk);
    zero_chk("reset");
    rst = 1'b1;
    cyc(1'b1, 0, 1'b1);
    for (int k = 0; k < NB; k++) begin
      beat("single", k, 0);
      cyc(1'b0, 0, 1'b1);
    end
    idle("single_end");
    cyc(1'b1, 0, 1'b0);
    prev = out_d;
    foreach (tv[i]) begin
      chk("bp_valid", 32'(out_valid), 32'(tv[i].ev));
      chk("bp_idx", 32'(out_idx), 32'(tv[i].eidx));
      chk("bp_d", out_d, tv[i].ed);
      chk("bp_last", 32'(out_last), 32'(tv[i].el));
      if (i > 0 && !tv[i-1].rdy) chk("bp_hold", out_d, prev);
      prev = out_d;
      cyc(1'b0, 0, tv[i].rdy);
    end
    idle("bp_end");
    cyc(1'b1, 0, 1'b1);
    for (int k = 0; k < NB; k++) begin
      beat("pp1", k, 0);
      cyc(k == 5, 100, 1'b1);
    end
    for (int k = 0; k < NB; k++) begin
      beat("pp2", k, 100);
      cyc(1'b0, 0, 1'b1);
    end
    idle("pp_end");
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 200, 1'b0);
    chk("ov_before", 32'(overflow), 32'd0);
    cyc(1'b1, 300, 1'b0);
    chk("ov_set", 32'(overflow), 32'd1);
    chk("ov_busy", 32'(busy), 32'd1);
    for (int k = 0; k < NB; k++) begin
      beat("ov1", k, 0);
      cyc(1'b0, 0, 1'b1);
    end
    for (int k = 0; k < NB; k++) begin
      beat("ov2", k, 200);
      cyc(1'b0, 0, 1'b1);
    end
    idle("ov_end");
    chk("ov_sticky", 32'(overflow), 32'd1);
    do_reset("rst_ov");
    cyc(1'b1, 0, 1'b0);
    cyc(1'b1, 400, 1'b0);
    for (int k = 0; k < NB; k++) begin
      beat("full1", k, 0);
      cyc(k == NB - 1, 500, 1'b1);
    end
    chk("full_noovf", 32'(overflow), 32'd0);
    for (int k = 0; k < NB; k++) begin
      beat("full2", k, 400);
      cyc(1'b0, 0, 1'b1);
    end
    for (int k = 0; k < NB; k++) begin
      beat("full3", k, 500);
      cyc(1'b0, 0, 1'b1);
    end
    idle("full_end");
    chk("full_ovf_end", 32'(overflow), 32'd0);
    cyc(1'b1, 0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      beat("rm", k, 0);
      cyc(1'b0, 0, 1'b1);
    end
    chk("rm_idx7", 32'(out_idx), 32'd7);
    do_reset("rm_rst");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 0, 1'b1);
      idle("rm_idle");
    end
    cyc(1'b1, 600, 1'b1);
    beat("rm_new", 0, 600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
